// File: rtl/umi_tx_arbiter_if.sv
// umi_tx_arbiter_if: N-to-1 UMI transmit bundle (requester side + shared port).
// slave = arbiter view, master = requesters/endpoint view.
interface umi_tx_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int IW = (N > 1) ? $clog2(N) : 1
);
  logic [N*DW-1:0] in_packet;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_packet;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_src;

  modport slave (
    input  in_packet, in_valid, out_ready,
    output in_ready, out_packet, out_valid, out_src
  );

  modport master (
    output in_packet, in_valid, out_ready,
    input  in_ready, out_packet, out_valid, out_src
  );
endinterface

// File: rtl/umi_tx_arbiter.sv
// umi_tx_arbiter: round-robin N-to-1 UMI TX arbiter with registered output.
// Ports: clk, nreset (async low), bus (umi_tx_arbiter_if.slave).
// Option: define UMI_ARB_PRIO0_EN for strict priority of requester 0.
module umi_tx_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input logic           clk,
  input logic           nreset,
  umi_tx_arbiter_if.slave bus
);

  localparam int M = (N > 1) ? N - 1 : 1;

  logic [DW-1:0] out_packet_q, out_packet_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_src_q, out_src_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          found;
  logic [IW-1:0] w;
  logic [N-1:0]  rdy;
  logic [DW-1:0] pk [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign pk[i] = bus.in_packet[i*DW +: DW];
  end

  assign load = !out_valid_q | bus.out_ready;

  always_comb begin : arb
    int idx;
    int base;
    logic [IW-1:0] ix;
    found = 1'b0;
    w     = '0;
    idx   = 0;
    base  = 0;
    ix    = '0;
`ifdef UMI_ARB_PRIO0_EN
    if (bus.in_valid[0]) begin
      found = 1'b1;
    end else if (N > 1) begin
      // ptr lives in 1..N-1; a reset value of 0 starts at 1
      base = (ptr_q == '0) ? 0 : int'(ptr_q) - 1;
      for (int k = 0; k < N - 1; k++) begin
        idx = 1 + (base + k) % M;
        ix  = IW'(idx);
        if (!found && bus.in_valid[ix]) begin
          found = 1'b1;
          w     = ix;
        end
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      ix  = IW'(idx);
      if (!found && bus.in_valid[ix]) begin
        found = 1'b1;
        w     = ix;
      end
    end
`endif
  end

  always_comb begin
    rdy = '0;
    if (nreset && load && found) rdy[w] = 1'b1;
  end

  assign bus.in_ready = rdy;

  always_comb begin
    out_packet_d = out_packet_q;
    out_valid_d  = out_valid_q;
    out_src_d    = out_src_q;
    ptr_d        = ptr_q;
    if (load) begin
      if (found) begin
        out_packet_d = pk[w];
        out_valid_d  = 1'b1;
        out_src_d    = w;
`ifdef UMI_ARB_PRIO0_EN
        if (w != '0)
          ptr_d = (w == IW'(N - 1)) ? IW'(1) : w + 1'b1;
`else
        ptr_d = (w == IW'(N - 1)) ? '0 : w + 1'b1;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_packet_q <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= '0;
      ptr_q        <= '0;
    end else begin
      out_packet_q <= out_packet_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.out_packet = out_packet_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_src    = out_src_q;

endmodule

// File: tb/tb_umi_tx_arbiter.sv
// tb_umi_tx_arbiter: directed bench for umi_tx_arbiter (N=4, DW=16).
// Queue-based reference model checked every cycle plus literal checks.
module tb_umi_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic nreset = 1'b1;

  umi_tx_arbiter_if #(.N(N), .DW(DW)) bus ();

  umi_tx_arbiter #(.N(N), .DW(DW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the priority order is an explicit list of requesters
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_pkt   = '0;
  int            m_src   = 0;
  int            m_ptr   = 0;
  int            m_w;
  logic [N-1:0]  exp_rdy;

  function automatic int pick(logic [N-1:0] v, int ptr);
    int order[$];
    int start;
`ifdef UMI_ARB_PRIO0_EN
    if (v[0]) return 0;
    start = (ptr < 1) ? 1 : ptr;
    for (int k = 0; k < N - 1; k++) order.push_back(1 + (start - 1 + k) % (N - 1));
`else
    start = ptr;
    for (int k = 0; k < N; k++) order.push_back((start + k) % N);
`endif
    foreach (order[j]) if (v[2'(order[j])]) return order[j];
    return -1;
  endfunction

  function automatic int next_ptr(int w, int ptr);
`ifdef UMI_ARB_PRIO0_EN
    if (w == 0) return ptr;
    return (w == N - 1) ? 1 : w + 1;
`else
    return (w + 1) % N;
`endif
  endfunction

  always_comb begin
    m_w = pick(bus.in_valid, m_ptr);
    exp_rdy = '0;
    if (nreset && (!m_valid || bus.out_ready) && m_w >= 0)
      exp_rdy = 4'(1 << m_w);
  end

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_valid <= 1'b0;
      m_pkt   <= '0;
      m_src   <= 0;
      m_ptr   <= 0;
    end else if (!m_valid || bus.out_ready) begin
      if (m_w >= 0) begin
        m_valid <= 1'b1;
        m_pkt   <= DW'(bus.in_packet >> (DW * m_w));
        m_src   <= m_w;
        m_ptr   <= next_ptr(m_w, m_ptr);
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("mdl_out_packet", 32'(bus.out_packet), 32'(m_pkt));
    chk("mdl_out_src", 32'(bus.out_src), 32'(m_src));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sq[$];
    bus.in_packet = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    #1 nreset = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_src", 32'(bus.out_src), 32'd0);
    chk("rst_out_packet", 32'(bus.out_packet), 32'd0);

    step();
    nreset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    chk("rel_src", 32'(bus.out_src), 32'd0);
    chk("rel_pkt", 32'(bus.out_packet), 32'hA0);

`ifndef UMI_ARB_PRIO0_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("fair_valid", 32'(bus.out_valid), 32'd1);
      chk("fair_src", 32'(bus.out_src), 32'(k % 4));
      chk("fair_pkt", 32'(bus.out_packet), 32'h A0 + 32'(k % 4));
    end

    step();
    bus.in_valid = 4'b1010;
    exp_sq = '{1, 3, 1, 3, 1};
    foreach (exp_sq[j]) begin
      @(negedge clk);
      chk("sparse_src", 32'(bus.out_src), 32'(exp_sq[j]));
      chk("sparse_rdy02", 32'(bus.in_ready & 4'b0101), 32'd0);
    end

    step();
    bus.in_valid  = 4'b0100;
    bus.in_packet = {16'hA3, 16'h0055, 16'hA1, 16'hA0};
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0101;
    bus.in_packet = {16'hA3, 16'h0055, 16'hA1, 16'h0066};
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_pkt", 32'(bus.out_packet), 32'h55);
      chk("stall_src", 32'(bus.out_src), 32'd2);
      chk("stall_rdy", 32'(bus.in_ready), 32'd0);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_rdy", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    chk("unstall_src", 32'(bus.out_src), 32'd0);
    chk("unstall_pkt", 32'(bus.out_packet), 32'h66);

    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 nreset = 1'b0;
    #1;
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rdy", 32'(bus.in_ready), 32'd0);
    chk("async_src", 32'(bus.out_src), 32'd0);
    step();
    nreset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rerel_rdy", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    chk("rerel_src", 32'(bus.out_src), 32'd0);
    chk("rerel_pkt", 32'(bus.out_packet), 32'h66);
`else
    repeat (4) begin
      @(negedge clk);
      chk("p0_src", 32'(bus.out_src), 32'd0);
      chk("p0_pkt", 32'(bus.out_packet), 32'hA0);
    end
    step();
    bus.in_valid = 4'b1110;
    exp_sq = '{0, 1, 2, 3, 1};
    foreach (exp_sq[j]) begin
      @(negedge clk);
      chk("p0_rr_src", 32'(bus.out_src), 32'(exp_sq[j]));
    end
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/umi_tx_arbiter.md
# umi_tx_arbiter

Round-robin arbiter that shares one UMI transmit port among N requesters, e.g. the per-core UMI TX ports of the RISC-V grid feeding the single `umi_tx_sim` endpoint. Each UMI packet is one DW-bit beat with a valid/ready handshake. The arbiter grants one requester per transfer into a registered output stage and rotates priority so that no requester starves.

## Interface
Parameters:
- N, 4, number of requesters (1..16)
- DW, 256, UMI packet width in bits
- IW, `$clog2(N)` (minimum 1), width of the grant index

Ports:
- clk  input  1  system clock; all logic on rising edge
- nreset  input  1  asynchronous, active-low reset
- in_packet  input  N*DW  requester packets; requester i occupies bits [i*DW +: DW]
- in_valid  input  N  requester i holds a packet
- in_ready  output  N  requester i's packet is accepted this cycle (one-hot or zero)
- out_packet  output  DW  registered packet to the shared port
- out_valid  output  1  out_packet is valid
- out_ready  input  1  shared port accepts out_packet
- out_src  output  IW  index of the requester that supplied out_packet

## Operation
- Output stage: one register holding out_packet, out_valid and out_src.
- `load = !out_valid | out_ready`. When load is 1, the stage can take a new packet this cycle.
- Arbitration is combinational over in_valid. The search starts at the priority pointer `ptr` and proceeds ptr, ptr+1, …, N-1, 0, …, ptr-1. The first requester with valid asserted is the winner `w`.
- `in_ready[w] = load & in_valid[w]`. All other in_ready bits are 0. in_ready never depends on anything except load, in_valid and ptr.
- On a transfer (some in_ready bit is 1):
  - out_packet ← in_packet[w]
  - out_valid ← 1
  - out_src ← w
  - ptr ← (w+1) mod N
- If load = 1 and no requester is valid, out_valid ← 0. out_packet and out_src hold their values.
- If load = 0, the stage holds. ptr is unchanged and all in_ready bits are 0.
- ptr advances only on a transfer, never on idle cycles.
- Wrap-around: with w = N-1, ptr becomes 0.
- A requester may drop in_valid without a transfer (non-UMI-compliant). The arbiter simply re-arbitrates and no state is corrupted.
- N = 1: the block degenerates to a pipeline register. ptr is constant 0 and out_src is 0.

## Timing
- Reset (nreset low, asynchronous assert):
  - out_valid = 0, out_packet = 0, out_src = 0, ptr = 0
  - in_ready = 0 because of the gating below
- Deassertion is taken synchronously on the next clk edge. The source is assumed to be externally synchronized.
- in_ready is forced to 0 while nreset is low.
- Latency: a packet accepted on edge k appears with out_valid = 1 after edge k. It is one cycle from in handshake to out_valid.
- Throughput: 1 packet per cycle while out_ready stays high.
- Back-to-back transfers: if out_valid = 1 and out_ready = 1, a new packet may be loaded in the same cycle. There is no bubble.
- Stall: while out_valid = 1 and out_ready = 0, out_packet and out_src are stable and all in_ready bits are 0.
- Reset mid-operation: a packet held in the output stage is discarded. Requesters with in_valid high re-arbitrate from ptr = 0 after reset release.

## Configuration
- `UMI_ARB_PRIO0_EN`
  - Defined: requester 0 has strict priority. If in_valid[0] = 1 and load = 1, requester 0 wins regardless of ptr, and ptr is not updated by a requester-0 grant. Requesters 1..N-1 round-robin among themselves using ptr over the range 1..N-1, wrapping from N-1 to 1.
  - Not defined: pure round-robin over all N requesters, as in Operation.

## Test plan
- Reset:
  - Stimulus: hold nreset low with all in_valid = 1 and out_ready = 1.
  - Required: out_valid = 0, in_ready = 0, out_src = 0, out_packet = 0.
  - Stimulus: release nreset.
  - Required: the first grant goes to requester 0, and out_packet = in_packet[0] one cycle later.
- Fairness:
  - Stimulus: N = 4, all four requesters continuously valid with packets 0xA0..0xA3, out_ready = 1.
  - Required: out_src sequence 0,1,2,3,0,1,… with one packet per cycle and no gaps.
- Sparse and wrap-around:
  - Stimulus: only requesters 1 and 3 valid; ptr reaches 0 after the grant to 3.
  - Required: out_src sequence 1,3,1,3; in_ready[0] and in_ready[2] are never asserted.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles while out_valid = 1 with packet 0x55 from requester 2.
  - Required: out_packet = 0x55 and out_src = 2 stable, all in_ready = 0.
  - Stimulus: raise out_ready.
  - Required: the next packet loads in the same cycle.
- Reset mid-stall:
  - Stimulus: assert nreset while out_valid = 1 and out_ready = 0.
  - Required: out_valid drops immediately (asynchronously). After release, requesters re-arbitrate from requester 0.
- `UMI_ARB_PRIO0_EN` defined:
  - Stimulus: requesters 0..3 all continuously valid.
  - Required: out_src = 0 every cycle.
  - Stimulus: drop in_valid[0].
  - Required: out_src sequence 1,2,3,1.
